// File: rtl/volume_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : volume_envelope                                                 |
// | Purpose  : Square-channel volume envelope. A free-running prescaler makes  |
// |            a 64 Hz tick; on each tick an active envelope counts down its   |
// |            step period and moves the volume one step toward 0 or 15.       |
// |            The registered amplitude gates the volume with the waveform,    |
// |            the length enable and the DAC power condition.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module volume_envelope #(
  parameter int CLOCKS64 = 515625
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_TRIGGER,
  input  logic [3:0] I_INIT_VOLUME,
  input  logic       I_ENV_INCREASE,
  input  logic [2:0] I_ENV_PERIOD,
  input  logic       I_WAVE,
  input  logic       I_WAVE_EN,
  output logic [3:0] O_AMPLITUDE,
  output logic [3:0] O_VOLUME,
  output logic       O_DAC_ON,
  output logic       O_ENV_ACTIVE
);

  localparam int                 c_PRE_W    = (CLOCKS64 > 1) ? $clog2(CLOCKS64) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLOCKS64 - 1);
  localparam logic [3:0]         c_VOL_MAX  = 4'd15;
  localparam logic [3:0]         c_VOL_MIN  = 4'd0;

  typedef enum logic [0:0] {
    ST_DONE   = 1'b0,
    ST_ACTIVE = 1'b1
  } env_state_t;

  logic [c_PRE_W-1:0] r_prescale;
  logic               w_tick;

  env_state_t         r_state,    w_state_nxt;
  logic [3:0]         r_volume,   w_volume_nxt;
  logic [2:0]         r_step,     w_step_nxt;
  logic [2:0]         r_period,   w_period_nxt;
  logic               r_increase, w_increase_nxt;

  logic               w_dac_on;
  logic               r_dac_on;
  logic [3:0]         r_amplitude;

  // The tick fires during the last prescaler count, i.e. on the wrapping edge.
  assign w_tick = (r_prescale == c_PRE_LAST);

  // The DAC is powered from the live register bits, not a trigger-time copy.
  assign w_dac_on = (I_INIT_VOLUME != 4'd0) || I_ENV_INCREASE;

  // Free-running 64 Hz prescaler; a trigger never restarts it.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + c_PRE_W'(1);
    end
  end

  // Envelope state register: state, volume, step counter and latched settings.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state    <= ST_DONE;
      r_volume   <= 4'd0;
      r_step     <= 3'd0;
      r_period   <= 3'd0;
      r_increase <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_volume   <= w_volume_nxt;
      r_step     <= w_step_nxt;
      r_period   <= w_period_nxt;
      r_increase <= w_increase_nxt;
    end
  end

  // Next-state logic: a trigger reloads everything and wins over a coincident tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_volume_nxt   = r_volume;
    w_step_nxt     = r_step;
    w_period_nxt   = r_period;
    w_increase_nxt = r_increase;

    if (I_TRIGGER) begin
      w_period_nxt   = I_ENV_PERIOD;
      w_increase_nxt = I_ENV_INCREASE;
      w_volume_nxt   = I_INIT_VOLUME;
      w_step_nxt     = I_ENV_PERIOD;
      w_state_nxt    = (I_ENV_PERIOD != 3'd0) ? ST_ACTIVE : ST_DONE;
    end else if (w_tick && (r_state == ST_ACTIVE)) begin
      if (r_step > 3'd1) begin
        w_step_nxt = r_step - 3'd1;
      end else begin
        // Period elapsed: reload and step, or stop once the rail is reached.
        w_step_nxt = r_period;
        if (r_increase) begin
          if (r_volume != c_VOL_MAX) begin
            w_volume_nxt = r_volume + 4'd1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          if (r_volume != c_VOL_MIN) begin
            w_volume_nxt = r_volume - 4'd1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
    end
  end

  // Registered mixer sample and DAC power flag.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_dac_on    <= 1'b0;
      r_amplitude <= 4'd0;
    end else begin
      r_dac_on    <= w_dac_on;
      r_amplitude <= (I_WAVE_EN && I_WAVE && w_dac_on) ? r_volume : 4'd0;
    end
  end

  assign O_AMPLITUDE  = r_amplitude;
  assign O_VOLUME     = r_volume;
  assign O_DAC_ON     = r_dac_on;
  assign O_ENV_ACTIVE = (r_state == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_volume_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_volume_envelope                                              |
// | Purpose  : Directed self-checking bench for volume_envelope with a short   |
// |            tick period; expected values are hand-derived per step.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_volume_envelope;

  localparam int CLOCKS64 = 4;

  logic       I_CLK = 1'b0;
  logic       I_RESET;
  logic       I_TRIGGER;
  logic [3:0] I_INIT_VOLUME;
  logic       I_ENV_INCREASE;
  logic [2:0] I_ENV_PERIOD;
  logic       I_WAVE;
  logic       I_WAVE_EN;
  logic [3:0] O_AMPLITUDE;
  logic [3:0] O_VOLUME;
  logic       O_DAC_ON;
  logic       O_ENV_ACTIVE;

  int passed = 0;
  int total  = 0;
  int pre    = 0;

  volume_envelope #(.CLOCKS64(CLOCKS64)) dut (
    .I_CLK          (I_CLK),
    .I_RESET        (I_RESET),
    .I_TRIGGER      (I_TRIGGER),
    .I_INIT_VOLUME  (I_INIT_VOLUME),
    .I_ENV_INCREASE (I_ENV_INCREASE),
    .I_ENV_PERIOD   (I_ENV_PERIOD),
    .I_WAVE         (I_WAVE),
    .I_WAVE_EN      (I_WAVE_EN),
    .O_AMPLITUDE    (O_AMPLITUDE),
    .O_VOLUME       (O_VOLUME),
    .O_DAC_ON       (O_DAC_ON),
    .O_ENV_ACTIVE   (O_ENV_ACTIVE)
  );

  always #5 I_CLK = ~I_CLK;

  // Reference prescaler used only to line stimulus up with tick edges.
  always @(posedge I_CLK) begin
    if (I_RESET)                pre <= 0;
    else if (pre == CLOCKS64-1) pre <= 0;
    else                        pre <= pre + 1;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge I_CLK);
  endtask

  // Stop at the negedge just before a tick edge.
  task automatic align_tick();
    int guard = 0;
    while ((pre != CLOCKS64-1) && (guard < 2*CLOCKS64)) begin
      @(negedge I_CLK);
      guard++;
    end
    check("align_tick", 4'(pre), 4'(CLOCKS64-1));
  endtask

  // One-cycle trigger; returns at the negedge after the trigger edge.
  task automatic trig(input logic [3:0] init, input logic inc, input logic [2:0] per);
    I_INIT_VOLUME  = init;
    I_ENV_INCREASE = inc;
    I_ENV_PERIOD   = per;
    I_TRIGGER      = 1'b1;
    cyc(1);
    I_TRIGGER      = 1'b0;
  endtask

  initial begin
    I_RESET = 1'b1; I_TRIGGER = 1'b0; I_INIT_VOLUME = 4'd0; I_ENV_INCREASE = 1'b0;
    I_ENV_PERIOD = 3'd0; I_WAVE = 1'b0; I_WAVE_EN = 1'b0;
    cyc(3);
    check("rst_vol", O_VOLUME, 4'd0);
    check("rst_amp", O_AMPLITUDE, 4'd0);
    check("rst_dac", {3'd0, O_DAC_ON}, 4'd0);
    check("rst_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    I_RESET = 1'b0;
    cyc(1);

    // Decreasing from 15 with period 1: one step per tick, amplitude one cycle behind.
    I_WAVE = 1'b1; I_WAVE_EN = 1'b1;
    align_tick(); cyc(1);
    trig(4'd15, 1'b0, 3'd1);
    check("dec_init_vol", O_VOLUME, 4'd15);
    check("dec_init_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
    cyc(1);
    check("dec_init_amp", O_AMPLITUDE, 4'd15);
    cyc(2);
    for (int k = 0; k < 15; k++) begin
      check("dec_vol", O_VOLUME, 4'(14 - k));
      check("dec_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
      check("dec_amp_old", O_AMPLITUDE, 4'(15 - k));
      cyc(1);
      check("dec_amp_new", O_AMPLITUDE, 4'(14 - k));
      cyc(3);
    end
    check("dec_done_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("dec_done_vol", O_VOLUME, 4'd0);

    // Increasing from 12 with period 3; settings changed afterwards must be ignored.
    align_tick(); cyc(1);
    trig(4'd12, 1'b1, 3'd3);
    I_ENV_INCREASE = 1'b0; I_ENV_PERIOD = 3'd1;
    check("inc_init_vol", O_VOLUME, 4'd12);
    check("inc_init_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
    cyc(10);
    check("inc_pre3_vol", O_VOLUME, 4'd12);
    cyc(1);
    check("inc_t3_vol", O_VOLUME, 4'd13);
    cyc(12);
    check("inc_t6_vol", O_VOLUME, 4'd14);
    cyc(12);
    check("inc_t9_vol", O_VOLUME, 4'd15);
    check("inc_t9_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
    cyc(11);
    check("inc_pre12_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
    cyc(1);
    check("inc_t12_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("inc_t12_vol", O_VOLUME, 4'd15);
    cyc(40);
    check("inc_hold_vol", O_VOLUME, 4'd15);
    check("inc_hold_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("inc_hold_amp", O_AMPLITUDE, 4'd15);

    // Period 0 freezes the envelope; then exercise the wave/enable gating.
    trig(4'd7, 1'b0, 3'd0);
    check("frz_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("frz_vol0", O_VOLUME, 4'd7);
    cyc(80);
    check("frz_vol", O_VOLUME, 4'd7);
    check("frz_act2", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("frz_amp", O_AMPLITUDE, 4'd7);
    I_WAVE = 1'b0;
    cyc(1);
    check("gate_wave0", O_AMPLITUDE, 4'd0);
    I_WAVE = 1'b1; I_WAVE_EN = 1'b0;
    cyc(1);
    check("gate_en0", O_AMPLITUDE, 4'd0);
    I_WAVE_EN = 1'b1;
    cyc(1);
    check("gate_on", O_AMPLITUDE, 4'd7);

    // Trigger on a tick edge: no step, counter loaded with the new period 2.
    align_tick();
    trig(4'd9, 1'b1, 3'd2);
    check("coin_vol", O_VOLUME, 4'd9);
    check("coin_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
    cyc(4);
    check("coin_t1_vol", O_VOLUME, 4'd9);
    cyc(3);
    check("coin_pre2_vol", O_VOLUME, 4'd9);
    cyc(1);
    check("coin_t2_vol", O_VOLUME, 4'd10);

    // DAC off: init 0 and decrease keeps the output silent whatever the wave does.
    trig(4'd0, 1'b0, 3'd1);
    check("dac_off", {3'd0, O_DAC_ON}, 4'd0);
    check("dac_off_vol", O_VOLUME, 4'd0);
    cyc(1);
    check("dac_off_amp1", O_AMPLITUDE, 4'd0);
    I_WAVE = 1'b0;
    cyc(1);
    check("dac_off_amp0", O_AMPLITUDE, 4'd0);
    I_WAVE = 1'b1;
    I_ENV_INCREASE = 1'b1;
    cyc(1);
    check("dac_on_inc", {3'd0, O_DAC_ON}, 4'd1);

    // Reset in mid-envelope together with a trigger.
    align_tick(); cyc(1);
    trig(4'd15, 1'b0, 3'd1);
    cyc(6);
    check("mid_vol", O_VOLUME, 4'd14);
    I_RESET = 1'b1; I_TRIGGER = 1'b1;
    I_INIT_VOLUME = 4'd10; I_ENV_INCREASE = 1'b1; I_ENV_PERIOD = 3'd1;
    cyc(1);
    check("rt_vol", O_VOLUME, 4'd0);
    check("rt_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("rt_dac", {3'd0, O_DAC_ON}, 4'd0);
    check("rt_amp", O_AMPLITUDE, 4'd0);
    I_RESET = 1'b0; I_TRIGGER = 1'b0;
    cyc(1);
    check("rt_dac_live", {3'd0, O_DAC_ON}, 4'd1);
    cyc(20);
    check("rt_hold_vol", O_VOLUME, 4'd0);
    check("rt_hold_act", {3'd0, O_ENV_ACTIVE}, 4'd0);
    check("rt_hold_amp", O_AMPLITUDE, 4'd0);
    trig(4'd3, 1'b1, 3'd1);
    check("rt_new_vol", O_VOLUME, 4'd3);
    check("rt_new_act", {3'd0, O_ENV_ACTIVE}, 4'd1);
    align_tick();
    check("rt_new_pre", O_VOLUME, 4'd3);
    cyc(1);
    check("rt_new_step", O_VOLUME, 4'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
